// File: rtl/mm_ctrl_pkg.sv
// Shared definitions for the matrix-multiply stream sequencer.
// Latency: n/a (types, defaults and derived element counts only).
// Backpressure: n/a.
package mm_ctrl_pkg;

  localparam int WIDTH_DEF        = 8;
  localparam int A_DEPTH_BITS_DEF = 3;
  localparam int B_DEPTH_BITS_DEF = 2;
  localparam int RES_DEPTH_BITS_DEF = 1;

  // Number of RAM locations addressed by a given number of address bits
  function automatic int elems(input int bits);
    return 1 << bits;
  endfunction

  localparam int A_ELEMS   = elems(A_DEPTH_BITS_DEF);
  localparam int B_ELEMS   = elems(B_DEPTH_BITS_DEF);
  localparam int RES_ELEMS = elems(RES_DEPTH_BITS_DEF);

  // Top-level control states; the result read-out phase lives in the streamer
  typedef enum logic [2:0] {
    CTL_IDLE      = 3'd0,
    CTL_RECV_A    = 3'd1,
    CTL_RECV_B    = 3'd2,
    CTL_START     = 3'd3,
    CTL_WAIT_DONE = 3'd4,
    CTL_STREAM    = 3'd5
  } ctl_state_t;

  // Result streamer states (RD_REQ / RD_LATCH / SEND plus its own idle)
  typedef enum logic [1:0] {
    STR_IDLE     = 2'd0,
    STR_RD_REQ   = 2'd1,
    STR_RD_LATCH = 2'd2,
    STR_SEND     = 2'd3
  } str_state_t;

endpackage

// File: rtl/res_axis_streamer.sv
// Reads each RES_RAM word and presents it on the master stream, TLAST on the final word.
// Latency: go -> TVALID in 3 cycles; one word per 3 cycles with downstream always ready.
// Backpressure: TVALID/TDATA/TLAST hold in SEND until TREADY; next read waits for the handshake.
module res_axis_streamer
  import mm_ctrl_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int RES_BITS = RES_DEPTH_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_go,
  output logic                o_finished,
  output logic                o_rd_en,
  output logic [RES_BITS-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]    i_rd_data,
  output logic [31:0]         o_m_tdata,
  output logic                o_m_tvalid,
  output logic                o_m_tlast,
  input  logic                i_m_tready
);

  localparam int RES_N = elems(RES_BITS);

  str_state_t          r_state;
  logic [RES_BITS-1:0] r_out_cnt;
  logic                r_rd_en;
  logic [RES_BITS-1:0] r_rd_addr;
  logic [31:0]         r_tdata;
  logic                r_tvalid;
  logic                r_tlast;

  // Final handshake of the frame hands control back to the top FSM
  assign o_finished = (r_state == STR_SEND) & i_m_tready & r_tlast;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_m_tdata  = r_tdata;
  assign o_m_tvalid = r_tvalid;
  assign o_m_tlast  = r_tlast;

  // Read/latch/send sequencer; the read strobe is raised on entry to RD_REQ so data lands in RD_LATCH
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= STR_IDLE;
      r_out_cnt <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
    end else begin
      case (r_state)
        STR_IDLE: begin
          if (i_go) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_out_cnt;
            r_state   <= STR_RD_REQ;
          end
        end
        STR_RD_REQ: begin
          r_rd_en <= 1'b0;
          r_state <= STR_RD_LATCH;
        end
        STR_RD_LATCH: begin
          r_tdata  <= {{(32-WIDTH){1'b0}}, i_rd_data};
          r_tvalid <= 1'b1;
          r_tlast  <= (r_out_cnt == RES_BITS'(RES_N - 1));
          r_state  <= STR_SEND;
        end
        STR_SEND: begin
          if (i_m_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            if (r_tlast) begin
              r_out_cnt <= '0;
              r_state   <= STR_IDLE;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_out_cnt + 1'b1;
              r_state   <= STR_RD_REQ;
            end
          end
        end
        default: r_state <= STR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mm_stream_sequencer.sv
// Loads one input frame into A_RAM/B_RAM, pulses Start, waits for Done, then streams RES_RAM out.
// Latency: RAM write 1 cycle after each input handshake; Start the cycle after the last one.
// Backpressure: S_AXIS_TREADY only in RECV_A/RECV_B; output holds under M_AXIS_TREADY low.
module mm_stream_sequencer
  import mm_ctrl_pkg::*;
#(
  parameter int width          = WIDTH_DEF,
  parameter int A_depth_bits   = A_DEPTH_BITS_DEF,
  parameter int B_depth_bits   = B_DEPTH_BITS_DEF,
  parameter int RES_depth_bits = RES_DEPTH_BITS_DEF
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [31:0]               S_AXIS_TDATA,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  output logic [31:0]               M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      Start,
  input  logic                      Done
);

  localparam int A_N   = elems(A_depth_bits);
  localparam int B_N   = elems(B_depth_bits);
  localparam int CNT_W = (A_depth_bits > B_depth_bits) ? A_depth_bits : B_depth_bits;

  ctl_state_t              r_state;
  logic [CNT_W-1:0]        r_in_cnt;
  logic                    r_a_we;
  logic [A_depth_bits-1:0] r_a_addr;
  logic [width-1:0]        r_a_dat;
  logic                    r_b_we;
  logic [B_depth_bits-1:0] r_b_addr;
  logic [width-1:0]        r_b_dat;
  logic                    r_start;
  logic                    w_s_hs;
  logic                    w_go;
  logic                    w_finished;
  logic                    w_unused_in;

  // Frame length is count-defined, so TLAST and the upper TDATA bits carry nothing we need
  assign w_unused_in = ^{S_AXIS_TLAST, S_AXIS_TDATA[31:width]};

  assign S_AXIS_TREADY = (r_state == CTL_RECV_A) | (r_state == CTL_RECV_B);
  assign w_s_hs        = S_AXIS_TVALID & S_AXIS_TREADY;
  // Done only counts while waiting for it; a stale pulse after reset lands elsewhere and is dropped
  assign w_go          = (r_state == CTL_WAIT_DONE) & Done;

  assign A_write_en      = r_a_we;
  assign A_write_address = r_a_addr;
  assign A_write_data_in = r_a_dat;
  assign B_write_en      = r_b_we;
  assign B_write_address = r_b_addr;
  assign B_write_data_in = r_b_dat;
  assign Start           = r_start;

  // Input capture and multiplier hand-off; write strobes and Start are single-cycle registered pulses
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state  <= CTL_IDLE;
      r_in_cnt <= '0;
      r_a_we   <= 1'b0;
      r_a_addr <= '0;
      r_a_dat  <= '0;
      r_b_we   <= 1'b0;
      r_b_addr <= '0;
      r_b_dat  <= '0;
      r_start  <= 1'b0;
    end else begin
      r_a_we  <= 1'b0;
      r_b_we  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        CTL_IDLE: r_state <= CTL_RECV_A;
        CTL_RECV_A: begin
          if (w_s_hs) begin
            r_a_we   <= 1'b1;
            r_a_addr <= r_in_cnt[A_depth_bits-1:0];
            r_a_dat  <= S_AXIS_TDATA[width-1:0];
            if (r_in_cnt == CNT_W'(A_N - 1)) begin
              r_in_cnt <= '0;
              r_state  <= CTL_RECV_B;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        CTL_RECV_B: begin
          if (w_s_hs) begin
            r_b_we   <= 1'b1;
            r_b_addr <= r_in_cnt[B_depth_bits-1:0];
            r_b_dat  <= S_AXIS_TDATA[width-1:0];
            if (r_in_cnt == CNT_W'(B_N - 1)) begin
              // Last B write commits during the START cycle, ahead of any multiplier read
              r_in_cnt <= '0;
              r_start  <= 1'b1;
              r_state  <= CTL_START;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        CTL_START:     r_state <= CTL_WAIT_DONE;
        CTL_WAIT_DONE: if (Done) r_state <= CTL_STREAM;
        CTL_STREAM:    if (w_finished) r_state <= CTL_IDLE;
        default:       r_state <= CTL_IDLE;
      endcase
    end
  end

  res_axis_streamer #(
    .WIDTH    (width),
    .RES_BITS (RES_depth_bits)
  ) u_streamer (
    .i_clk      (ACLK),
    .i_rst_n    (ARESETN),
    .i_go       (w_go),
    .o_finished (w_finished),
    .o_rd_en    (RES_read_en),
    .o_rd_addr  (RES_read_address),
    .i_rd_data  (RES_read_data_out),
    .o_m_tdata  (M_AXIS_TDATA),
    .o_m_tvalid (M_AXIS_TVALID),
    .o_m_tlast  (M_AXIS_TLAST),
    .i_m_tready (M_AXIS_TREADY)
  );

endmodule

// File: tb/tb_mm_stream_sequencer.sv
// Bench for mm_stream_sequencer with behavioural RAMs and a behavioural multiplier (2x4 times 4x1).
// Result element i = bits [15:8] of sum_k A[i][k]*B[k].
// Directed scenarios followed by randomized frames, checked against a reference computed from the stimulus.
module tb_mm_stream_sequencer;

  localparam int W  = 8;
  localparam int AB = 3;
  localparam int BB = 2;
  localparam int RB = 1;
  localparam int AN = 8;
  localparam int BN = 4;
  localparam int RN = 2;
  localparam int NW = AN + BN;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [31:0]   S_AXIS_TDATA;
  logic          S_AXIS_TVALID;
  logic          S_AXIS_TLAST;
  logic          S_AXIS_TREADY;
  logic [31:0]   M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY;
  logic          A_write_en;
  logic [AB-1:0] A_write_address;
  logic [W-1:0]  A_write_data_in;
  logic          B_write_en;
  logic [BB-1:0] B_write_address;
  logic [W-1:0]  B_write_data_in;
  logic          RES_read_en;
  logic [RB-1:0] RES_read_address;
  logic [W-1:0]  RES_read_data_out;
  logic          Start;
  logic          Done;

  always #5 ACLK = ~ACLK;

  mm_stream_sequencer #(
    .width(W), .A_depth_bits(AB), .B_depth_bits(BB), .RES_depth_bits(RB)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .A_write_en(A_write_en), .A_write_address(A_write_address), .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
    .RES_read_data_out(RES_read_data_out),
    .Start(Start), .Done(Done)
  );

  // ---------------- behavioural RAMs and write logs ----------------
  logic [7:0] a_ram [AN];
  logic [7:0] b_ram [BN];
  logic [7:0] res_ram [RN];
  logic [7:0] res_q;
  int         a_log_addr [$];
  int         b_log_addr [$];
  logic [7:0] a_log_dat [$];
  logic [7:0] b_log_dat [$];
  int         cyc = 0;

  assign RES_read_data_out = res_q;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (A_write_en) begin
      a_ram[A_write_address] <= A_write_data_in;
      a_log_addr.push_back(int'(A_write_address));
      a_log_dat.push_back(A_write_data_in);
    end
    if (B_write_en) begin
      b_ram[B_write_address] <= B_write_data_in;
      b_log_addr.push_back(int'(B_write_address));
      b_log_dat.push_back(B_write_data_in);
    end
    if (RES_read_en) res_q <= res_ram[RES_read_address];
  end

  // ---------------- behavioural multiplier (no reset) ----------------
  int mul_delay   = 5;
  int start_count = 0;
  int done_cyc    = 0;

  initial begin
    Done = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      if (Start) begin
        start_count++;
        repeat (mul_delay) @(posedge ACLK);
        #1;
        for (int i = 0; i < RN; i++) begin
          int acc;
          acc = 0;
          for (int k = 0; k < BN; k++) acc += int'(a_ram[i*BN+k]) * int'(b_ram[k]);
          res_ram[i] = acc[15:8];
        end
        Done = 1'b1;
        done_cyc = cyc;
        @(posedge ACLK); #1;
        Done = 1'b0;
      end
    end
  end

  // ---------------- checking helpers and reference ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] fw [NW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_res(input int row);
    int acc;
    acc = 0;
    for (int k = 0; k < BN; k++) acc += int'(fw[row*BN+k]) * int'(fw[AN+k]);
    return 8'((acc / 256) % 256);
  endfunction

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic fill_const(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b);
    for (int i = 0; i < NW; i++) fw[i] = (i < BN) ? a0 : (i < AN) ? a1 : b;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) fw[i] = 8'($urandom());
  endtask

  // gap_mode: 0 back-to-back, 1 alternate valid/idle, 2 random idle cycles
  task automatic send_words(input int gap_mode, input int n_words);
    int budget;
    for (int i = 0; i < n_words; i++) begin
      if (gap_mode == 1 && i > 0) begin S_AXIS_TVALID = 1'b0; tick(); end
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) begin S_AXIS_TVALID = 1'b0; tick(); end
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = {24'($urandom()), fw[i]};
      S_AXIS_TLAST  = 1'($urandom());
      budget = 0;
      while (!S_AXIS_TREADY && budget < 50) begin tick(); budget++; end
      if (!S_AXIS_TREADY) begin
        check("in_tready_timeout", 32'(S_AXIS_TREADY), 32'd1);
        break;
      end
      tick();
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic recv_frame(input int bp_cycles);
    int budget;
    int t_prev;
    logic busy_ready;
    busy_ready = 1'b0;
    t_prev = 0;
    for (int r = 0; r < RN; r++) begin
      M_AXIS_TREADY = (bp_cycles == 0 || r > 0);
      budget = 0;
      while (!M_AXIS_TVALID && budget < 200) begin
        busy_ready |= S_AXIS_TREADY;
        tick();
        budget++;
      end
      check("out_tvalid", 32'(M_AXIS_TVALID), 32'd1);
      if (r == 0) check("done_to_tvalid", 32'(cyc - done_cyc), 32'd3);
      else if (bp_cycles == 0) check("word_period", 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
      check("out_tdata", M_AXIS_TDATA, {24'h0, ref_res(r)});
      check("out_tlast", 32'(M_AXIS_TLAST), 32'(r == RN - 1));
      if (r == 0 && bp_cycles > 0) begin
        repeat (bp_cycles) begin
          tick();
          busy_ready |= S_AXIS_TREADY;
          check("bp_tvalid_hold", 32'(M_AXIS_TVALID), 32'd1);
          check("bp_tdata_hold", M_AXIS_TDATA, {24'h0, ref_res(0)});
          check("bp_tlast_hold", 32'(M_AXIS_TLAST), 32'd0);
          check("bp_no_early_read", 32'(RES_read_en), 32'd0);
        end
        M_AXIS_TREADY = 1'b1;
      end
      tick();
      check("tvalid_after_hs", 32'(M_AXIS_TVALID), 32'd0);
    end
    M_AXIS_TREADY = 1'b0;
    check("tready_low_busy", 32'(busy_ready), 32'd0);
    check("idle_gap_tready", 32'(S_AXIS_TREADY), 32'd0);
    tick();
    check("tready_reassert", 32'(S_AXIS_TREADY), 32'd1);
  endtask

  task automatic check_writes();
    check("a_wr_count", 32'(a_log_addr.size()), 32'(AN));
    for (int i = 0; i < AN && i < a_log_addr.size(); i++) begin
      check("a_wr_addr", 32'(a_log_addr[i]), 32'(i));
      check("a_wr_data", 32'(a_log_dat[i]), 32'(fw[i]));
    end
    check("b_wr_count", 32'(b_log_addr.size()), 32'(BN));
    for (int i = 0; i < BN && i < b_log_addr.size(); i++) begin
      check("b_wr_addr", 32'(b_log_addr[i]), 32'(i));
      check("b_wr_data", 32'(b_log_dat[i]), 32'(fw[AN+i]));
    end
  endtask

  task automatic clear_logs();
    a_log_addr.delete(); a_log_dat.delete();
    b_log_addr.delete(); b_log_dat.delete();
  endtask

  task automatic run_frame(input int gap_mode, input int bp_cycles);
    int sc0;
    sc0 = start_count;
    clear_logs();
    send_words(gap_mode, NW);
    check("start_pulse", 32'(Start), 32'd1);
    check("tready_in_start", 32'(S_AXIS_TREADY), 32'd0);
    tick();
    check("start_one_cycle", 32'(Start), 32'd0);
    recv_frame(bp_cycles);
    check_writes();
    check("start_count", 32'(start_count - sc0), 32'd1);
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b0;
    tick();
    tick();
    check("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_m_tdata", M_AXIS_TDATA, 32'd0);
    check("rst_m_tlast", 32'(M_AXIS_TLAST), 32'd0);
    check("rst_wr_en", 32'({A_write_en, B_write_en}), 32'd0);
    check("rst_rd_en", 32'(RES_read_en), 32'd0);
    check("rst_start", 32'(Start), 32'd0);
    ARESETN = 1'b1;
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int sc0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b0;
    ARESETN       = 1'b0;

    // reset state, then one IDLE cycle before TREADY rises
    apply_reset();
    check("idle_after_reset", 32'(S_AXIS_TREADY), 32'd0);
    tick();
    check("recv_a_tready", 32'(S_AXIS_TREADY), 32'd1);

    // nominal frame
    fill_const(8'h10, 8'h10, 8'h20);
    run_frame(0, 0);

    // saturating values
    fill_const(8'hFF, 8'h00, 8'hFF);
    run_frame(0, 0);

    // input gaps
    fill_const(8'h10, 8'h10, 8'h20);
    run_frame(1, 0);

    // output backpressure on the first result
    run_frame(0, 5);

    // reset after 10 input words, then a full nominal frame
    fill_random();
    send_words(0, 10);
    apply_reset();
    fill_const(8'h10, 8'h10, 8'h20);
    run_frame(0, 0);

    // reset while waiting for Done: the late Done lands during the next frame's input
    fill_random();
    mul_delay = 12;
    clear_logs();
    sc0 = start_count;
    send_words(0, NW);
    check("stale_start", 32'(Start), 32'd1);
    tick(); tick(); tick();
    apply_reset();
    mul_delay = 5;
    check("stale_start_count", 32'(start_count - sc0), 32'd1);
    fill_random();
    run_frame(2, 0);

    // back-to-back randomized frames
    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame(int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0) ? 3 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
